// File: rtl/ram_responder.sv
// ram_responder
// -------------
// Memory-side responder for the lab RAM access interface. It zero-fills a
// DEPTH x DW register file after reset (INIT), then serves one write or
// read request per cycle (RUN) and returns one response per request with
// one cycle of latency.
//
// Optional feature: RAM_RESPONDER_STATS_EN builds the saturating accepted
// write/read counters. When it is undefined, wr_cnt and rd_cnt are tied to 0.
//
// Ports:
//   clk, rstn        clock; synchronous active-low reset
//   req_valid/ready  request handshake
//   req_we           1 = write, 0 = read
//   req_addr         request address
//   req_wdata        write data
//   rsp_valid/ready  response handshake
//   rsp_we           echo of req_we for this response
//   rsp_rdata        read data, or the written data for writes
//   init_done        zero-fill complete
//   dbg_addr         debug read address
//   dbg_data         combinational mem[dbg_addr]
//   wr_cnt, rd_cnt   saturating accepted write/read counters
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its payload stable while valid && !ready.
// req_ready is combinational from state and rsp_ready. The response
// payload is registered and holds while rsp_valid && !rsp_ready.
//
// The FSM state is held in state_q, and checkers can bind to it.

module ram_responder #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic          init_done_q, init_done_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_we_q, rsp_we_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DW-1:0] mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          accept;

    // A response slot is free when it is empty or is being drained this cycle.
    assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = '0;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_PTR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                // A new accept overrides the drain, so the slot refills
                // back-to-back.
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = req_we;
                    // A read sees memory as it was before this edge.
                    rsp_rdata_d = req_we ? req_wdata : mem[req_addr];
                    mem_we      = req_we;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage has no reset. It is cleared by the INIT sweep instead. Writes are
    // blocked while reset is asserted, so a request in the reset cycle cannot
    // land.
    always_ff @(posedge clk) begin
        if (rstn && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign dbg_data  = mem[dbg_addr];

`ifdef RAM_RESPONDER_STATS_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        // Counters saturate and never wrap.
        if (accept && req_we && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (accept && !req_we && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`else
    assign wr_cnt = {CW{1'b0}};
    assign rd_cnt = {CW{1'b0}};
`endif

endmodule
